// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS datapath: opcodes, control FSM states,
// and the alu_op / alu_src_b / pc_src select codes used by control, ALU decoder and datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Encodings 14 and 15 are unused and recover to RST_S.
    typedef enum logic [3:0] {
        RST_S    = 4'd0,
        FETCH_S  = 4'd1,
        DECODE_S = 4'd2,
        MEMADR_S = 4'd3,
        MEMRD_S  = 4'd4,
        MEMWB_S  = 4'd5,
        MEMWR_S  = 4'd6,
        EXEC_S   = 4'd7,
        ALUWB_S  = 4'd8,
        BRANCH_S = 4'd9,
        ADDIEX_S = 4'd10,
        ADDIWB_S = 4'd11,
        JUMP_S   = 4'd12,
        TRAP_S   = 4'd13
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath; Moore outputs, with the FETCH
// IR/PC enables additionally qualified by mem_ready so they pulse only on the completing cycle.
module multicycle_control
    import mips_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [1:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state, state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RST_S;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = RST_S;
        case (state)
            RST_S:    state_nxt = FETCH_S;
            FETCH_S:  state_nxt = mem_ready ? DECODE_S : FETCH_S;
            DECODE_S: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = MEMADR_S;
                    OP_RTYPE:     state_nxt = EXEC_S;
                    OP_BEQ:       state_nxt = BRANCH_S;
                    OP_ADDI:      state_nxt = ADDIEX_S;
                    OP_J:         state_nxt = JUMP_S;
                    default:      state_nxt = TRAP_ON_ILLEGAL ? TRAP_S : FETCH_S;
                endcase
            end
            MEMADR_S: state_nxt = (opcode == OP_SW) ? MEMWR_S : MEMRD_S;
            MEMRD_S:  state_nxt = mem_ready ? MEMWB_S : MEMRD_S;
            MEMWB_S:  state_nxt = FETCH_S;
            MEMWR_S:  state_nxt = mem_ready ? FETCH_S : MEMWR_S;
            EXEC_S:   state_nxt = ALUWB_S;
            ALUWB_S:  state_nxt = FETCH_S;
            BRANCH_S: state_nxt = FETCH_S;
            ADDIEX_S: state_nxt = ADDIWB_S;
            ADDIWB_S: state_nxt = FETCH_S;
            JUMP_S:   state_nxt = FETCH_S;
            TRAP_S:   state_nxt = TRAP_S;
            default:  state_nxt = RST_S;
        endcase
    end

    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        pc_src        = PCSRC_ALU;
        alu_op        = ALUOP_ADD;
        illegal_op    = 1'b0;
        case (state)
            FETCH_S: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            // Branch target is precomputed here while the opcode is decoded.
            DECODE_S: alu_src_b = SRCB_IMM_SH2;
            MEMADR_S, ADDIEX_S: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            MEMRD_S: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEMWB_S: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR_S: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXEC_S: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB_S: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH_S: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
            end
            ADDIWB_S: reg_write = 1'b1;
            JUMP_S: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
            end
            TRAP_S:  illegal_op = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: trapping and non-trapping instances share stimulus;
// per-cycle expectations are queued by the stimulus and retired by a negedge monitor.
module tb_multicycle_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;

    // {ir_write, pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b[1:0], pc_src[1:0], alu_op[1:0], illegal_op}
    wire [16:0] o_a, o_b;
    wire [3:0]  st_a, st_b;

    always #5 clk = ~clk;

    multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .ir_write(o_a[16]), .pc_write(o_a[15]), .pc_write_cond(o_a[14]), .iord(o_a[13]),
        .mem_read(o_a[12]), .mem_write(o_a[11]), .mem_to_reg(o_a[10]), .reg_dst(o_a[9]),
        .reg_write(o_a[8]), .alu_src_a(o_a[7]), .alu_src_b(o_a[6:5]), .pc_src(o_a[4:3]),
        .alu_op(o_a[2:1]), .illegal_op(o_a[0]), .state_o(st_a)
    );

    multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .ir_write(o_b[16]), .pc_write(o_b[15]), .pc_write_cond(o_b[14]), .iord(o_b[13]),
        .mem_read(o_b[12]), .mem_write(o_b[11]), .mem_to_reg(o_b[10]), .reg_dst(o_b[9]),
        .reg_write(o_b[8]), .alu_src_a(o_b[7]), .alu_src_b(o_b[6:5]), .pc_src(o_b[4:3]),
        .alu_op(o_b[2:1]), .illegal_op(o_b[0]), .state_o(st_b)
    );

    typedef struct {
        logic [3:0] st_a;
        logic [3:0] st_b;
        logic       mr;
        int         idx;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_idx = 0;
    int   rw_cnt = 0;
    int   mtr_cnt = 0;
    int   ir_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected output vector for a state, straight from the control table.
    function automatic logic [16:0] exp_outs(input logic [3:0] st, input logic mr);
        logic irw, pcw, pcc, io, mrd, mwr, m2r, rd, rw, sa, ill;
        logic [1:0] sb, ps, ao;
        {irw, pcw, pcc, io, mrd, mwr, m2r, rd, rw, sa, ill} = '0;
        sb = 2'b00; ps = 2'b00; ao = 2'b00;
        case (st)
            4'd1:  begin mrd = 1'b1; sb = 2'b01; irw = mr; pcw = mr; end
            4'd2:  sb = 2'b11;
            4'd3:  begin sa = 1'b1; sb = 2'b10; end
            4'd4:  begin mrd = 1'b1; io = 1'b1; end
            4'd5:  begin rw = 1'b1; m2r = 1'b1; end
            4'd6:  begin mwr = 1'b1; io = 1'b1; end
            4'd7:  begin sa = 1'b1; ao = 2'b10; end
            4'd8:  begin rw = 1'b1; rd = 1'b1; end
            4'd9:  begin sa = 1'b1; ao = 2'b01; pcc = 1'b1; ps = 2'b01; end
            4'd10: begin sa = 1'b1; sb = 2'b10; end
            4'd11: rw = 1'b1;
            4'd12: begin pcw = 1'b1; ps = 2'b10; end
            4'd13: ill = 1'b1;
            default: ;
        endcase
        return {irw, pcw, pcc, io, mrd, mwr, m2r, rd, rw, sa, sb, ps, ao, ill};
    endfunction

    task automatic step(input logic rst_v, input logic [5:0] op, input logic mr,
                        input logic [3:0] ea, input logic [3:0] eb);
        exp_t e;
        @(negedge clk);
        reset = rst_v;
        opcode = op;
        mem_ready = mr;
        e.st_a = ea; e.st_b = eb; e.mr = mr; e.idx = step_idx;
        sb_q.push_back(e);
        step_idx++;
        #3;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_val($sformatf("state_a#%0d", e.idx), {28'd0, st_a}, {28'd0, e.st_a});
                check_val($sformatf("outs_a#%0d", e.idx), {15'd0, o_a}, {15'd0, exp_outs(e.st_a, e.mr)});
                check_val($sformatf("state_b#%0d", e.idx), {28'd0, st_b}, {28'd0, e.st_b});
                check_val($sformatf("outs_b#%0d", e.idx), {15'd0, o_b}, {15'd0, exp_outs(e.st_b, e.mr)});
                rw_cnt  += int'(o_a[8]);
                mtr_cnt += int'(o_a[10]);
                ir_cnt  += int'(o_a[16]);
            end
        end
    end

    initial begin
        // Reset held three cycles, released, then FETCH.
        repeat (3) step(1'b0, OP_RTYPE, 1'b0, RST_S, RST_S);
        step(1'b1, OP_RTYPE, 1'b0, RST_S, RST_S);

        // R-type, zero wait.
        rw_cnt = 0;
        step(1'b1, OP_RTYPE, 1'b1, FETCH_S, FETCH_S);
        step(1'b1, OP_RTYPE, 1'b1, DECODE_S, DECODE_S);
        step(1'b1, OP_RTYPE, 1'b1, EXEC_S, EXEC_S);
        step(1'b1, OP_RTYPE, 1'b1, ALUWB_S, ALUWB_S);
        check_val("rtype_regwr_cycles", rw_cnt, 1);

        // lw with two memory wait cycles in MEMRD.
        rw_cnt = 0; mtr_cnt = 0;
        step(1'b1, OP_LW, 1'b1, FETCH_S, FETCH_S);
        step(1'b1, OP_LW, 1'b1, DECODE_S, DECODE_S);
        step(1'b1, OP_LW, 1'b1, MEMADR_S, MEMADR_S);
        step(1'b1, OP_LW, 1'b0, MEMRD_S, MEMRD_S);
        step(1'b1, OP_LW, 1'b0, MEMRD_S, MEMRD_S);
        step(1'b1, OP_LW, 1'b1, MEMRD_S, MEMRD_S);
        step(1'b1, OP_LW, 1'b1, MEMWB_S, MEMWB_S);
        check_val("lw_regwr_cycles", rw_cnt, 1);
        check_val("lw_memtoreg_cycles", mtr_cnt, 1);

        // Fetch stalled four cycles, then j; mem_ready ignored in DECODE/JUMP.
        ir_cnt = 0;
        repeat (4) step(1'b1, OP_J, 1'b0, FETCH_S, FETCH_S);
        step(1'b1, OP_J, 1'b1, FETCH_S, FETCH_S);
        step(1'b1, OP_J, 1'b0, DECODE_S, DECODE_S);
        step(1'b1, OP_J, 1'b0, JUMP_S, JUMP_S);
        check_val("fetch_irwrite_pulses", ir_cnt, 1);

        // sw with one wait cycle.
        step(1'b1, OP_SW, 1'b1, FETCH_S, FETCH_S);
        step(1'b1, OP_SW, 1'b1, DECODE_S, DECODE_S);
        step(1'b1, OP_SW, 1'b1, MEMADR_S, MEMADR_S);
        step(1'b1, OP_SW, 1'b0, MEMWR_S, MEMWR_S);
        step(1'b1, OP_SW, 1'b1, MEMWR_S, MEMWR_S);

        // beq.
        step(1'b1, OP_BEQ, 1'b1, FETCH_S, FETCH_S);
        step(1'b1, OP_BEQ, 1'b1, DECODE_S, DECODE_S);
        step(1'b1, OP_BEQ, 1'b1, BRANCH_S, BRANCH_S);

        // addi with mem_ready low where it must be ignored.
        step(1'b1, OP_ADDI, 1'b1, FETCH_S, FETCH_S);
        step(1'b1, OP_ADDI, 1'b0, DECODE_S, DECODE_S);
        step(1'b1, OP_ADDI, 1'b0, ADDIEX_S, ADDIEX_S);
        step(1'b1, OP_ADDI, 1'b0, ADDIWB_S, ADDIWB_S);

        // Illegal opcode: instance a traps, instance b falls back to FETCH.
        step(1'b1, 6'h3f, 1'b1, FETCH_S, FETCH_S);
        step(1'b1, 6'h3f, 1'b0, DECODE_S, DECODE_S);
        repeat (3) step(1'b1, 6'h3f, 1'b0, TRAP_S, FETCH_S);
        step(1'b0, OP_SW, 1'b0, RST_S, RST_S);
        step(1'b1, OP_SW, 1'b0, RST_S, RST_S);

        // Asynchronous reset in the middle of MEMWR.
        step(1'b1, OP_SW, 1'b1, FETCH_S, FETCH_S);
        step(1'b1, OP_SW, 1'b1, DECODE_S, DECODE_S);
        step(1'b1, OP_SW, 1'b1, MEMADR_S, MEMADR_S);
        step(1'b1, OP_SW, 1'b0, MEMWR_S, MEMWR_S);
        @(negedge clk);
        #1;
        check_val("pre_rst_mem_write", {31'd0, o_a[11]}, 32'd1);
        check_val("pre_rst_state", {28'd0, st_a}, {28'd0, MEMWR_S});
        reset = 1'b0;
        #1;
        check_val("async_rst_mem_write_a", {31'd0, o_a[11]}, 32'd0);
        check_val("async_rst_state_a", {28'd0, st_a}, {28'd0, RST_S});
        check_val("async_rst_outs_a", {15'd0, o_a}, 32'd0);
        check_val("async_rst_state_b", {28'd0, st_b}, {28'd0, RST_S});
        check_val("async_rst_outs_b", {15'd0, o_b}, 32'd0);
        step(1'b1, OP_SW, 1'b0, RST_S, RST_S);
        step(1'b1, OP_SW, 1'b0, FETCH_S, FETCH_S);

        repeat (2) @(negedge clk);
        #4;
        check_val("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch into the instruction register, PC update, memory access, ALU source selection and register-file writeback.
- Consumes the opcode field (instruction bits 31:26) and a memory-ready handshake. Drives every datapath enable and mux select.
- The ALU function decoder is a separate block that receives alu_op from this one.

Parameters:
- TRAP_ON_ILLEGAL, 1, 1: an unknown opcode enters TRAP. 0: an unknown opcode is a NOP and the FSM returns to FETCH after DECODE.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- mem_ready  in  1  memory completes the current read/write this cycle
- ir_write  out  1  instruction-register enable
- pc_write  out  1  unconditional PC write
- pc_write_cond  out  1  PC write if ALU zero (beq)
- iord  out  1  memory address: 0=PC, 1=ALU out
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_to_reg  out  1  writeback data: 0=ALU out, 1=memory data
- reg_dst  out  1  destination: 0=rt, 1=rd
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- pc_src  out  2  00=ALU result, 01=ALU out reg, 10=jump target
- alu_op  out  2  00=add, 01=sub, 10=use funct
- illegal_op  out  1  sticky trap flag
- state_o  out  4  current state encoding, for debug/verification

Behaviour:
- Outputs are Moore: a pure decode of the state register, except ir_write/pc_write in FETCH, which are also gated by mem_ready.
- Reset asserted (reset=0): state forced to RST_S immediately, whatever state it was in. illegal_op=0. All outputs 0.
- Reset deasserted: RST_S moves to FETCH on the next rising edge.
- Default for every output in every state is 0 unless listed below.
- Opcode decode:
  - 000000 R-type
  - 100011 lw
  - 101011 sw
  - 000100 beq
  - 001000 addi
  - 000010 j
- States and transitions:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=pc_write=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state:
    - lw, sw → MEMADR
    - R-type → EXEC
    - beq → BRANCH
    - addi → ADDIEX
    - j → JUMP
    - other → TRAP (TRAP_ON_ILLEGAL=1) or FETCH (0)
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw → MEMRD, sw → MEMWR.
  - MEMRD: mem_read=1, iord=1. Wait for mem_ready, then → MEMWB.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. → FETCH.
  - MEMWR: mem_write=1, iord=1. Wait for mem_ready, then → FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. → ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. → FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. → ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. → FETCH.
  - JUMP: pc_write=1, pc_src=10. → FETCH.
  - TRAP: illegal_op=1 and all other outputs 0. Stays in TRAP until reset.
- Zero-wait latency (FETCH to the next FETCH):
  - j, beq: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
  - Each memory wait cycle adds 1.
- opcode is sampled only in DECODE and MEMADR. It must stay stable because ir_write is 0 outside FETCH.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- mem_read and mem_write are never both 1.
- Only one of reg_write, mem_write, pc_write is asserted in any non-FETCH state.
- Unused state encodings fall to RST_S on the next edge.

Decomposition:
- Shared package mips_pkg:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - 4-bit state encodings
  - alu_op, alu_src_b and pc_src encodings
  - The ALU decoder and datapath top reuse these.
- No sub-module: a single state register with next-state and output decode. The separate alu_decoder stays outside this block.

Test Plan:
- Reset held low 3 cycles, then released → all outputs 0 and state_o=RST_S. One cycle later FETCH with mem_read=1, alu_src_b=01.
- Opcode 000000, mem_ready=1 continuously → state sequence FETCH, DECODE, EXEC, ALUWB, FETCH. reg_write=1 and reg_dst=1 only in ALUWB.
- Opcode 100011, mem_ready low 2 cycles in MEMRD → MEMRD held 3 cycles. reg_write=1, mem_to_reg=1 once in MEMWB. Total 7 cycles.
- FETCH with mem_ready=0 for 4 cycles → ir_write=pc_write=0 throughout. Both pulse for exactly 1 cycle when mem_ready rises.
- Opcode 111111, TRAP_ON_ILLEGAL=1 → TRAP after DECODE, illegal_op=1 held. A reset pulse clears it. With TRAP_ON_ILLEGAL=0 → FETCH after DECODE and illegal_op stays 0.
- Reset asserted mid-MEMWR with mem_write=1 → mem_write drops to 0 in the same cycle (asynchronous), state_o=RST_S.
